hpm_event_shaper: RTL and testbench

//  Upstream stage of the HPM counter block: converts multi-count-per-cycle raw core events
//  (e.g. 2 instructions retired per cycle) into the 1-bit-per-cycle event vector the counters

---
 rtl/hpm_event_shaper.sv | 82 ++++++++
 tb/tb_hpm_event_shaper.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hpm_event_shaper.sv
// Per-event backlog shaper: turns multi-count-per-cycle core events into single-cycle pulses
// for the HPM counters, with a staging register, saturating backlog and sticky loss flags.
module hpm_event_shaper #(
    parameter int HPM_NUM_EVENTS = 28,
    parameter int INC_WIDTH      = 2,
    parameter int PEND_WIDTH     = 6
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [HPM_NUM_EVENTS*INC_WIDTH-1:0] events_inc_i,
    input  logic                                flush_i,
    input  logic                                lost_clr_i,
    output logic [HPM_NUM_EVENTS:1]             events_o,
    output logic [HPM_NUM_EVENTS:1]             lost_o,
    output logic                                busy_o
);

    localparam logic [PEND_WIDTH:0]   PMAX_EXT  = {1'b0, {PEND_WIDTH{1'b1}}};
    localparam logic [PEND_WIDTH-1:0] PMAX      = {PEND_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] PEND_ZERO = {PEND_WIDTH{1'b0}};
    localparam logic [INC_WIDTH-1:0]  INC_ZERO  = {INC_WIDTH{1'b0}};

    logic [INC_WIDTH-1:0]      inc_r  [1:HPM_NUM_EVENTS];
    logic [PEND_WIDTH-1:0]     pend_r [1:HPM_NUM_EVENTS];
    logic [PEND_WIDTH-1:0]     pend_s [1:HPM_NUM_EVENTS];
    logic [HPM_NUM_EVENTS:1]   lost_r;
    logic [HPM_NUM_EVENTS:1]   lost_s;

    // Output decode: a pulse whenever the backlog is nonzero; busy covers staged counts too.
    always_comb begin
        busy_o = 1'b0;
        for (int k = 1; k <= HPM_NUM_EVENTS; k++) begin
            events_o[k] = |pend_r[k];
            busy_o      = busy_o | (|pend_r[k]) | (|inc_r[k]);
        end
    end

    assign lost_o = lost_r;

    // Backlog update: add staged increment, drain one pulse, clamp at PMAX and flag the overflow.
    always_comb begin
        logic [PEND_WIDTH:0] sum_v;
        logic                sat_v;
        sum_v = {(PEND_WIDTH+1){1'b0}};
        sat_v = 1'b0;
        for (int k = 1; k <= HPM_NUM_EVENTS; k++) begin
            sum_v = {1'b0, pend_r[k]}
                  + {{(PEND_WIDTH+1-INC_WIDTH){1'b0}}, inc_r[k]}
                  - {{PEND_WIDTH{1'b0}}, events_o[k]};
            if (flush_i) begin
                pend_s[k] = PEND_ZERO;
                sat_v     = 1'b0;
            end else if (sum_v > PMAX_EXT) begin
                pend_s[k] = PMAX;
                sat_v     = 1'b1;
            end else begin
                pend_s[k] = sum_v[PEND_WIDTH-1:0];
                sat_v     = 1'b0;
            end
            // A saturation in the clear cycle must survive the clear.
            lost_s[k] = (lost_clr_i ? 1'b0 : lost_r[k]) | sat_v;
        end
    end

    // State registers: input staging, backlog and sticky loss flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= HPM_NUM_EVENTS; k++) begin
                inc_r[k]  <= INC_ZERO;
                pend_r[k] <= PEND_ZERO;
            end
            lost_r <= {HPM_NUM_EVENTS{1'b0}};
        end else begin
            for (int k = 1; k <= HPM_NUM_EVENTS; k++) begin
                inc_r[k]  <= flush_i ? INC_ZERO : events_inc_i[k*INC_WIDTH-1 -: INC_WIDTH];
                pend_r[k] <= pend_s[k];
            end
            lost_r <= lost_s;
        end
    end

endmodule

// File: tb/tb_hpm_event_shaper.sv
// Scoreboard bench for hpm_event_shaper: a count-level backlog model predicts every cycle's
// outputs into a queue; a monitor pops and compares once per clock.
module tb_hpm_event_shaper;

    localparam int N    = 28;
    localparam int IW   = 2;
    localparam int PMAX = 63;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N*IW-1:0]   events_inc_i = '0;
    logic              flush_i = 1'b0;
    logic              lost_clr_i = 1'b0;
    logic [N:1]        events_o;
    logic [N:1]        lost_o;
    logic              busy_o;

    hpm_event_shaper #(.HPM_NUM_EVENTS(N), .INC_WIDTH(IW), .PEND_WIDTH(6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .events_inc_i (events_inc_i),
        .flush_i      (flush_i),
        .lost_clr_i   (lost_clr_i),
        .events_o     (events_o),
        .lost_o       (lost_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [N:1] ev;
        logic [N:1] lost;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int m_stage [1:N];
    int m_back  [1:N];
    bit m_lost  [1:N];
    int drv_inc [1:N];

    int n_total = 0;
    int n_pass  = 0;
    int watch_k = 1;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic clear_inc();
        for (int k = 1; k <= N; k++) drv_inc[k] = 0;
    endtask

    // One clock of stimulus: drive on the falling edge, predict the post-edge outputs.
    task automatic step(input bit fl, input bit cl, input bit rs);
        exp_t e;
        int   out, nb;
        bit   sat;
        @(negedge clk_i);
        if (events_o[watch_k]) pulse_cnt++;
        for (int k = 1; k <= N; k++) events_inc_i[k*IW-1 -: IW] = drv_inc[k][IW-1:0];
        flush_i    = fl;
        lost_clr_i = cl;
        rst_i      = rs;
        e = '0;
        for (int k = 1; k <= N; k++) begin
            if (rs) begin
                m_stage[k] = 0;
                m_back[k]  = 0;
                m_lost[k]  = 1'b0;
            end else begin
                out = (m_back[k] > 0) ? 1 : 0;
                nb  = m_back[k] + m_stage[k] - out;
                sat = 1'b0;
                if (fl) nb = 0;
                else if (nb > PMAX) begin
                    nb  = PMAX;
                    sat = 1'b1;
                end
                m_lost[k]  = (cl ? 1'b0 : m_lost[k]) | sat;
                m_stage[k] = fl ? 0 : drv_inc[k];
                m_back[k]  = nb;
            end
            e.ev[k]   = (m_back[k] != 0);
            e.lost[k] = m_lost[k];
            e.busy    = e.busy | (m_back[k] != 0) | (m_stage[k] != 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        clear_inc();
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT against the oldest prediction shortly after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("events_o", {36'd0, events_o}, {36'd0, mon_e.ev});
            check("lost_o",   {36'd0, lost_o},   {36'd0, mon_e.lost});
            check("busy_o",   {63'd0, busy_o},   {63'd0, mon_e.busy});
        end
    end

    initial begin
        clear_inc();
        for (int k = 1; k <= N; k++) begin
            m_stage[k] = 0;
            m_back[k]  = 0;
            m_lost[k]  = 1'b0;
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // Single burst of 3 on event 1.
        watch_k = 1; pulse_cnt = 0;
        drv_inc[1] = 3;
        step(1'b0, 1'b0, 1'b0);
        idle(10);
        check("s1_pulses", 64'(pulse_cnt), 64'd3);

        // Event 5 at 2/cycle for 10 cycles -> 20 pulses.
        watch_k = 5; pulse_cnt = 0;
        clear_inc(); drv_inc[5] = 2;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        idle(25);
        check("s2_pulses", 64'(pulse_cnt), 64'd20);

        // Saturate event 3, then drain exactly PMAX pulses.
        clear_inc(); drv_inc[3] = 3;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #2;
        check("s3_lost3_set", {63'd0, lost_o[3]}, 64'd1);
        watch_k = 3;
        idle(1);
        pulse_cnt = 0;
        idle(80);
        check("s3_drain_pulses", 64'(pulse_cnt), 64'd63);
        clear_inc();
        step(1'b0, 1'b1, 1'b0);
        idle(2);

        // Flush mid-drain on event 2 with a new increment in the flush cycle.
        drv_inc[2] = 2;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        drv_inc[2] = 3;
        step(1'b1, 1'b0, 1'b0);
        watch_k = 2; pulse_cnt = 0;
        idle(6);
        check("s4_no_pulses", 64'(pulse_cnt), 64'd0);

        // Saturation on event 7 coincides with a lost clear; event 4's flag must clear.
        drv_inc[4] = 3; drv_inc[7] = 3;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
        drv_inc[4] = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        @(posedge clk_i); #2;
        check("s5_lost7_kept", {63'd0, lost_o[7]}, 64'd1);
        check("s5_lost4_clr",  {63'd0, lost_o[4]}, 64'd0);
        idle(70);

        // Reset with every event backlogged, then resume.
        for (int k = 1; k <= N; k++) drv_inc[k] = 3;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        drv_inc[9] = 2;
        step(1'b0, 1'b0, 1'b0);
        idle(4);

        // Randomized traffic with occasional flush, clear and reset.
        for (int blk = 0; blk < 8; blk++) begin
            int maxv;
            maxv = $urandom_range(0, 3);
            for (int i = 0; i < 50; i++) begin
                for (int k = 1; k <= N; k++) drv_inc[k] = $urandom_range(0, maxv);
                step(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 149) == 0));
            end
        end
        idle(70);

        @(posedge clk_i); #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
